// File: rtl/md5_work_scheduler_pkg.sv
// Shared types and constants for the MD5 work scheduler.
package md5_sched_pkg;

   // Scheduler FSM states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_KEY_W     = 32;
   localparam int DEF_CHUNK     = 256;

   // Upper bounds for the slice helper: up to 16 cores with keys up to 64 bits.
   localparam int MAX_KEY_W = 64;
   localparam int MAX_BUS_W = 16 * MAX_KEY_W;

   // Extracts slice idx (width w) of a packed per-core key bus, zero-extended.
   function automatic logic [MAX_KEY_W-1:0] key_slice(
      input logic [MAX_BUS_W-1:0] bus,
      input int unsigned          idx,
      input int unsigned          w
   );
      logic [MAX_KEY_W-1:0] raw;
      logic [MAX_KEY_W-1:0] mask;
      raw  = MAX_KEY_W'(bus >> (idx * w));
      mask = (64'd1 << w) - 64'd1;
      return raw & mask;
   endfunction

endpackage

// File: rtl/md5_work_scheduler_if.sv
// Core-array and result bus of the MD5 work scheduler.
//
// Result channel: result_key is transferred on a rising clock edge where
// result_valid && result_ready; once result_valid is raised, result_valid and
// result_key stay stable until that edge, and result_valid never depends on
// result_ready.
interface md5_work_scheduler_if
   import md5_sched_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int KEY_W     = DEF_KEY_W
) ();

   logic [NUM_CORES-1:0]       req;
   logic [NUM_CORES-1:0]       grant;
   logic [KEY_W-1:0]           work_base;
   logic                       work_valid;
   logic                       halt;
   logic [NUM_CORES-1:0]       found;
   logic [NUM_CORES*KEY_W-1:0] found_key;
   logic                       result_valid;
   logic [KEY_W-1:0]           result_key;
   logic                       result_ready;

   // Scheduler side.
   modport master (
      input  req, found, found_key, result_ready,
      output grant, work_base, work_valid, halt, result_valid, result_key
   );

   // Core array / result consumer side.
   modport slave (
      output req, found, found_key, result_ready,
      input  grant, work_base, work_valid, halt, result_valid, result_key
   );

endinterface

// File: rtl/md5_work_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick starting at rr_ptr,
// pointer moves past the winner when the pick is taken.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         req_masked,
   input  logic                 advance,
   output logic [N-1:0]         gnt_onehot,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] rr_ptr;

   // Search from rr_ptr upward with wrap; first requester wins.
   always_comb begin
      int c;
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      c          = 0;
      for (int i = 0; i < N; i++) begin
         c = int'(rr_ptr) + i;
         if (c >= N) c = c - N;
         if (!any && req_masked[c]) begin
            any           = 1'b1;
            gnt_idx       = IDX_W'(c);
            gnt_onehot[c] = 1'b1;
         end
      end
   end

   // Pointer update: next search starts just after the taken winner.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (advance && any) begin
         rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/md5_work_scheduler.sv
// Hands out CHUNK-sized key ranges to NUM_CORES MD5 cores round-robin,
// then latches the first reported key and offers it on the result channel.
module md5_work_scheduler
   import md5_sched_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int KEY_W     = DEF_KEY_W,
   parameter int CHUNK     = DEF_CHUNK
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         rewind,
   output logic                         busy,
   output logic                         exhausted,
   output state_t                       fsm_state,
   output logic [$clog2(NUM_CORES)-1:0] last_core,
   md5_work_scheduler_if.master         bus
);

   localparam int IDX_W = $clog2(NUM_CORES);
   localparam logic [KEY_W:0] CHUNK_EXT = (KEY_W + 1)'(CHUNK);

   state_t               state_q;
   state_t               state_next;
   logic [KEY_W-1:0]     next_base;
   logic [KEY_W:0]       base_sum;
   logic [NUM_CORES-1:0] grant_q;
   logic                 work_valid_q;
   logic [KEY_W-1:0]     work_base_q;
   logic                 result_valid_q;
   logic [KEY_W-1:0]     result_key_q;
   logic                 exhausted_q;
   logic                 dispatch;
   logic                 take_found;
   logic [NUM_CORES-1:0] arb_onehot;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;
   logic [IDX_W-1:0]     found_idx;
   logic [MAX_BUS_W-1:0] found_key_ext;
   logic [MAX_KEY_W-1:0] found_slice;

   // A core whose grant is high this cycle cannot win again immediately.
   rr_arbiter #(.N(NUM_CORES)) u_arb (
      .clock      (clock),
      .reset      (reset && !rewind),
      .req_masked (bus.req & ~grant_q),
      .advance    (dispatch),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx),
      .any        (arb_any)
   );

   // Carry out of this sum marks the last chunk of the key space.
   assign base_sum = {1'b0, next_base} + CHUNK_EXT;

   // Lowest-index reporting core wins.
   always_comb begin
      found_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (bus.found[i]) found_idx = IDX_W'(i);
      end
   end

   // Widen the per-core key bus to the helper's fixed width and pick the slice.
   always_comb begin
      found_key_ext = '0;
      found_key_ext[NUM_CORES*KEY_W-1:0] = bus.found_key;
      found_slice = key_slice(found_key_ext, 32'(found_idx), KEY_W);
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_next;
   end

   // Next state plus dispatch/capture decisions; found beats dispatch, rewind beats all.
   always_comb begin
      state_next = state_q;
      dispatch   = 1'b0;
      take_found = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (|bus.found) begin
               take_found = 1'b1;
               state_next = ST_REPORT;
            end else if (arb_any) begin
               dispatch = 1'b1;
               if (base_sum[KEY_W]) state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (|bus.found) begin
               take_found = 1'b1;
               state_next = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (result_valid_q && bus.result_ready) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_DONE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (rewind) begin
         state_next = ST_IDLE;
         dispatch   = 1'b0;
         take_found = 1'b0;
      end
   end

   // Registered dispatch outputs, base counter, result latch and sticky exhausted.
   always_ff @(posedge clock) begin
      if (!reset) begin
         next_base      <= '0;
         grant_q        <= '0;
         work_valid_q   <= 1'b0;
         work_base_q    <= '0;
         result_valid_q <= 1'b0;
         result_key_q   <= '0;
         exhausted_q    <= 1'b0;
         last_core      <= '0;
      end else begin
         grant_q      <= '0;
         work_valid_q <= 1'b0;
         if (rewind) begin
            next_base      <= '0;
            result_valid_q <= 1'b0;
            exhausted_q    <= 1'b0;
         end else begin
            if (dispatch) begin
               grant_q      <= arb_onehot;
               work_valid_q <= 1'b1;
               work_base_q  <= next_base;
               last_core    <= arb_idx;
               next_base    <= base_sum[KEY_W-1:0];
               if (base_sum[KEY_W]) exhausted_q <= 1'b1;
            end
            if (take_found) begin
               result_valid_q <= 1'b1;
               result_key_q   <= found_slice[KEY_W-1:0];
            end else if (state_q == ST_REPORT && result_valid_q && bus.result_ready) begin
               result_valid_q <= 1'b0;
            end
         end
      end
   end

   assign busy             = (state_q == ST_RUN) || (state_q == ST_WAIT);
   assign bus.halt         = !busy;
   assign bus.grant        = grant_q;
   assign bus.work_valid   = work_valid_q;
   assign bus.work_base    = work_base_q;
   assign bus.result_valid = result_valid_q;
   assign bus.result_key   = result_key_q;
   assign exhausted        = exhausted_q;
   assign fsm_state        = state_q;

endmodule

// File: tb/tb_md5_work_scheduler.sv
// Directed bench: default scheduler (4 cores, 32-bit keys, chunk 256) and a
// small one (12-bit keys, chunk 1024) for the key-space exhaustion path.
module tb_md5_work_scheduler;
   import md5_sched_pkg::*;

   logic   clock;
   logic   reset;
   logic   start0, rewind0, busy0, exh0;
   logic   start1, rewind1, busy1, exh1;
   state_t st0, st1;
   logic [1:0] last0, last1;

   int checks;
   int errors;

   md5_work_scheduler_if #(.NUM_CORES(4), .KEY_W(32)) bus0 ();
   md5_work_scheduler_if #(.NUM_CORES(4), .KEY_W(12)) bus1 ();

   md5_work_scheduler #(.NUM_CORES(4), .KEY_W(32), .CHUNK(256)) dut0 (
      .clock     (clock),
      .reset     (reset),
      .start     (start0),
      .rewind    (rewind0),
      .busy      (busy0),
      .exhausted (exh0),
      .fsm_state (st0),
      .last_core (last0),
      .bus       (bus0)
   );

   md5_work_scheduler #(.NUM_CORES(4), .KEY_W(12), .CHUNK(1024)) dut1 (
      .clock     (clock),
      .reset     (reset),
      .start     (start1),
      .rewind    (rewind1),
      .busy      (busy1),
      .exhausted (exh1),
      .fsm_state (st1),
      .last_core (last1),
      .bus       (bus1)
   );

   // Clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks a dispatch cycle of the default instance.
   task automatic chk_grant0(input string tag, input logic [3:0] g, input logic [31:0] base);
      chk({tag, "_grant"}, 64'(bus0.grant), 64'(g));
      chk({tag, "_valid"}, 64'(bus0.work_valid), 64'(g != 4'b0));
      chk({tag, "_base"}, 64'(bus0.work_base), 64'(base));
   endtask

   task automatic chk_grant1(input string tag, input logic [3:0] g, input logic [11:0] base);
      chk({tag, "_grant"}, 64'(bus1.grant), 64'(g));
      chk({tag, "_valid"}, 64'(bus1.work_valid), 64'(g != 4'b0));
      chk({tag, "_base"}, 64'(bus1.work_base), 64'(base));
   endtask

   task automatic chk_reset0(input string tag);
      chk({tag, "_state"}, 64'(st0), 64'(ST_IDLE));
      chk({tag, "_grant"}, 64'(bus0.grant), 64'h0);
      chk({tag, "_wvalid"}, 64'(bus0.work_valid), 64'h0);
      chk({tag, "_wbase"}, 64'(bus0.work_base), 64'h0);
      chk({tag, "_rvalid"}, 64'(bus0.result_valid), 64'h0);
      chk({tag, "_rkey"}, 64'(bus0.result_key), 64'h0);
      chk({tag, "_exh"}, 64'(exh0), 64'h0);
      chk({tag, "_halt"}, 64'(bus0.halt), 64'h1);
      chk({tag, "_busy"}, 64'(busy0), 64'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      start0 = 1'b0; rewind0 = 1'b0;
      start1 = 1'b0; rewind1 = 1'b0;
      bus0.req = '0; bus0.found = '0; bus0.found_key = '0; bus0.result_ready = 1'b0;
      bus1.req = '0; bus1.found = '0; bus1.found_key = '0; bus1.result_ready = 1'b0;

      // Reset state.
      step();
      step();
      chk_reset0("rst0");
      chk("rst1_state", 64'(st1), 64'(ST_IDLE));
      chk("rst1_halt", 64'(bus1.halt), 64'h1);

      // Start with all four cores requesting.
      reset = 1'b1; start0 = 1'b1; bus0.req = 4'b1111;
      step();
      chk("run_state", 64'(st0), 64'(ST_RUN));
      chk("run_busy", 64'(busy0), 64'h1);
      chk("run_halt", 64'(bus0.halt), 64'h0);
      chk("run_nogrant", 64'(bus0.grant), 64'h0);

      // Round-robin over all requesters, consecutive cycles.
      step(); chk_grant0("rr0", 4'b0001, 32'h000);
      step(); chk_grant0("rr1", 4'b0010, 32'h100);
      step(); chk_grant0("rr2", 4'b0100, 32'h200);
      step(); chk_grant0("rr3", 4'b1000, 32'h300);
      step(); chk_grant0("rr4", 4'b0001, 32'h400);
      step(); chk_grant0("rr5", 4'b0010, 32'h500);
      step(); chk_grant0("rr6", 4'b0100, 32'h600);
      chk("last_core2", 64'(last0), 64'h2);

      // Sparse requesters after core 2: core 0 then core 2.
      bus0.req = 4'b0101;
      step(); chk_grant0("sp0", 4'b0001, 32'h700);
      step(); chk_grant0("sp1", 4'b0100, 32'h800);

      // Single requester: every other cycle, base held in between.
      bus0.req = 4'b0010;
      step(); chk_grant0("one0", 4'b0010, 32'h900);
      step(); chk_grant0("one1", 4'b0000, 32'h900);
      step(); chk_grant0("one2", 4'b0010, 32'hA00);

      // Found on cores 1 and 2 together with a request from core 3.
      bus0.req = 4'b1000;
      bus0.found = 4'b0110;
      bus0.found_key = {32'h0, 32'h12345678, 32'hDEADBEEF, 32'h0};
      step();
      chk("fnd_grant", 64'(bus0.grant), 64'h0);
      chk("fnd_valid", 64'(bus0.result_valid), 64'h1);
      chk("fnd_key", 64'(bus0.result_key), 64'hDEADBEEF);
      chk("fnd_halt", 64'(bus0.halt), 64'h1);
      chk("fnd_state", 64'(st0), 64'(ST_REPORT));

      // Result held while the consumer stalls; later found pulses ignored.
      bus0.found = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_valid", 64'(bus0.result_valid), 64'h1);
         chk("hold_key", 64'(bus0.result_key), 64'hDEADBEEF);
         chk("hold_grant", 64'(bus0.grant), 64'h0);
         bus0.found = 4'b0000;
      end
      bus0.result_ready = 1'b1;
      step();
      chk("done_valid", 64'(bus0.result_valid), 64'h0);
      chk("done_state", 64'(st0), 64'(ST_DONE));
      bus0.result_ready = 1'b0;
      step();
      chk("done_start_ignored", 64'(st0), 64'(ST_DONE));
      chk("done_grant", 64'(bus0.grant), 64'h0);

      // Rewind out of DONE, then run again from base 0.
      rewind0 = 1'b1; bus0.req = 4'b1111;
      step();
      chk("rw_state", 64'(st0), 64'(ST_IDLE));
      chk("rw_halt", 64'(bus0.halt), 64'h1);
      rewind0 = 1'b0;
      step();
      chk("rw_run", 64'(st0), 64'(ST_RUN));
      step(); chk_grant0("rw0", 4'b0001, 32'h000);
      step(); chk_grant0("rw1", 4'b0010, 32'h100);
      step(); chk_grant0("rw2", 4'b0100, 32'h200);
      step(); chk_grant0("rw3", 4'b1000, 32'h300);

      // Rewind mid-run together with a found report.
      rewind0 = 1'b1;
      bus0.found = 4'b0001;
      bus0.found_key = {32'h0, 32'h12345678, 32'hDEADBEEF, 32'hCAFEF00D};
      step();
      chk("rwf_state", 64'(st0), 64'(ST_IDLE));
      chk("rwf_grant", 64'(bus0.grant), 64'h0);
      chk("rwf_wvalid", 64'(bus0.work_valid), 64'h0);
      chk("rwf_halt", 64'(bus0.halt), 64'h1);
      chk("rwf_rvalid", 64'(bus0.result_valid), 64'h0);
      rewind0 = 1'b0;
      bus0.found = 4'b0000;
      step();
      chk("rwf_run", 64'(st0), 64'(ST_RUN));
      step(); chk_grant0("rwf0", 4'b0001, 32'h000);

      // Enter REPORT via core 2, then reset while the result is pending.
      bus0.found = 4'b0100;
      step();
      chk("rep_state", 64'(st0), 64'(ST_REPORT));
      chk("rep_key", 64'(bus0.result_key), 64'h12345678);
      chk("rep_valid", 64'(bus0.result_valid), 64'h1);
      reset = 1'b0;
      bus0.found = 4'b0000;
      step();
      chk_reset0("rstrep");

      // Exhaustion on the 12-bit instance with a single requester.
      reset = 1'b1; start0 = 1'b0;
      start1 = 1'b1; bus1.req = 4'b0001;
      step();
      chk("ex_run", 64'(st1), 64'(ST_RUN));
      step(); chk_grant1("ex0", 4'b0001, 12'h000);
      step(); chk_grant1("ex0g", 4'b0000, 12'h000);
      step(); chk_grant1("ex1", 4'b0001, 12'h400);
      step(); chk_grant1("ex1g", 4'b0000, 12'h400);
      step(); chk_grant1("ex2", 4'b0001, 12'h800);
      chk("ex2_exh", 64'(exh1), 64'h0);
      step(); chk_grant1("ex2g", 4'b0000, 12'h800);
      step(); chk_grant1("ex3", 4'b0001, 12'hC00);
      chk("ex3_exh", 64'(exh1), 64'h1);
      chk("ex3_state", 64'(st1), 64'(ST_WAIT));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("exw_grant", 64'(bus1.grant), 64'h0);
         chk("exw_busy", 64'(busy1), 64'h1);
         chk("exw_halt", 64'(bus1.halt), 64'h0);
      end
      chk("idle0_stays", 64'(st0), 64'(ST_IDLE));

      // Found while waiting on the exhausted key space.
      bus1.found = 4'b0010;
      bus1.found_key = {12'h0, 12'h0, 12'h5A5, 12'h0};
      step();
      chk("exf_state", 64'(st1), 64'(ST_REPORT));
      chk("exf_key", 64'(bus1.result_key), 64'h5A5);
      chk("exf_valid", 64'(bus1.result_valid), 64'h1);
      chk("exf_busy", 64'(busy1), 64'h0);
      chk("exf_exh", 64'(exh1), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/md5_work_scheduler.md
Name: md5_work_scheduler

Overview:
- Distributes candidate-key ranges to NUM_CORES parallel MD5 brute-force cores.
- Grants one requesting core per cycle, round-robin, and hands it the next base key from a shared counter.
- Collects "found" reports, halts all cores, and presents the single winning key to the generator/UART path through a valid/ready handshake.
- Sits between the top-level start/rewind controls and the core array.

Parameters:
- NUM_CORES, 4, number of MD5 cores served (2..16).
- KEY_W, 32, width of candidate key / base counter.
- CHUNK, 256, keys per work unit; power of two, less than 2**KEY_W.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level; IDLE -> RUN when high.
- rewind  in  1  synchronous restart: base to 0, state to IDLE.
- req  in  NUM_CORES  core i requests a work unit.
- grant  out  NUM_CORES  one-hot grant, one-cycle pulse.
- work_base  out  KEY_W  base key for the granted core; valid with work_valid.
- work_valid  out  1  high exactly when grant is non-zero.
- halt  out  1  broadcast stop to all cores.
- found  in  NUM_CORES  core i found the target; key on its found_key slice.
- found_key  in  NUM_CORES*KEY_W  slice i is bits [i*KEY_W +: KEY_W].
- result_valid  out  1  result_key valid.
- result_key  out  KEY_W  winning key.
- result_ready  in  1  consumer accepts the result.
- busy  out  1  high in RUN or WAIT.
- exhausted  out  1  sticky; key space fully dispatched.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, next_base=0, rr_ptr=0.
  - grant=0, work_valid=0, work_base=0.
  - result_valid=0, result_key=0, exhausted=0.
  - halt=1, busy=0.
- States: IDLE, RUN, WAIT, REPORT, DONE.
- halt=1 in every state except RUN and WAIT. busy=1 in RUN and WAIT.
- IDLE:
  - No grants.
  - Goes to RUN when start=1.
- RUN arbitration, all outputs registered:
  - req sampled in cycle t produces grant/work_valid/work_base in cycle t+1.
  - Candidates are req & ~grant. A core whose grant is currently high is masked, so the same request cannot be granted twice.
  - Round-robin search starts at index rr_ptr. After a grant to core k, rr_ptr=(k+1) mod NUM_CORES.
  - On a grant: work_base=next_base, then next_base += CHUNK, computed at width KEY_W+1.
- Exhaustion:
  - If the carry-out of next_base+CHUNK is 1, that grant is the last one.
  - Set exhausted=1 and go RUN -> WAIT. Base wraps to 0 but is not dispatched.
- WAIT:
  - No grants.
  - Waits for found or rewind; remains indefinitely otherwise.
- Found handling, in RUN or WAIT, when any found bit is 1:
  - Pick the lowest index i with found[i]=1.
  - Latch result_key=found_key slice i and set result_valid=1 in the next cycle.
  - Go to REPORT.
  - No grant is issued in that cycle, even if req is high. Found has priority over dispatch.
- REPORT:
  - result_valid and result_key are held stable until result_ready=1.
  - Handshake completes on the edge where result_valid&&result_ready; then result_valid=0 and state goes to DONE.
  - Further found pulses are ignored.
- DONE:
  - No grants, result_valid=0.
  - Leaves only via rewind or reset. start is ignored.
- rewind, in any state:
  - Next cycle: state=IDLE, next_base=0, rr_ptr=0.
  - grant=0, work_valid=0, result_valid=0, exhausted=0.
  - rewind overrides found and req in the same cycle. reset overrides rewind.
  - rewind during REPORT drops the pending result without a handshake.
- start deasserted during RUN is ignored; the run continues.
- work_base is held at its last value while work_valid=0.

Decomposition:
- Shared package md5_sched_pkg holds:
  - state enum (IDLE, RUN, WAIT, REPORT, DONE).
  - default KEY_W and CHUNK constants.
  - a helper function for found_key slice extraction.
- One sub-module, rr_arbiter:
  - parameter N.
  - inputs clock, reset, req_masked, advance.
  - outputs gnt_onehot (combinational), gnt_idx, any.
  - owns rr_ptr.

Test Plan:
- Defaults (N=4, W=32, CHUNK=256):
  - reset, start=1, req=4'b1111 held.
  - Grants 0,1,2,3,0 on consecutive cycles with work_base 0x000,0x100,0x200,0x300,0x400.
  - Never two consecutive grants to one core.
- After granting core 2, req=4'b0101:
  - Next grant is core 0, then core 2.
  - Single requester req=4'b0010 is granted at most every other cycle.
- found=4'b0110 with slice1=0xDEADBEEF and slice2=0x12345678, same cycle as req=4'b1000:
  - No grant that cycle or after.
  - result_valid=1 next cycle with result_key=0xDEADBEEF; halt=1.
  - Held across 3 cycles of result_ready=0; dropped one cycle after result_ready=1; state DONE.
- Exhaustion, KEY_W=12, CHUNK=1024, req=4'b0001:
  - Bases 0x000,0x400,0x800,0xC00 are granted, then exhausted=1.
  - No further grants; busy stays 1 until found.
- rewind mid-RUN after base 0x300:
  - Next cycle: grant=0, halt=1, state IDLE.
  - After start, the first work_base is 0x000 to core 0.
  - rewind asserted together with found: no result_valid.
- Reset:
  - reset=0 asserted during REPORT: all outputs return to their reset values on the next edge.
